// File: rtl/modn_pkg.sv
// Shared types and helpers for the mod-N down-timer.
// Contents:
//   state_t       - controller states (IDLE, RUN, DONE)
//   clamp_to_mod  - limits a requested value to the largest legal count, n-1
package modn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Any value above n-1 is replaced by n-1.
    function automatic int unsigned clamp_to_mod(input int unsigned value,
                                                 input int unsigned n);
        return (value > n - 1) ? n - 1 : value;
    endfunction

endpackage

// File: rtl/modn_prescaler.sv
// Tick divider: passes through every PRESCALE-th qualified tick.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset
//   clear    - synchronous restart of the divide sequence
//   tick_in  - raw tick qualifier
//   tick_out - high in the cycle tick_in completes a group of PRESCALE ticks
// Used by modn_down_timer only when MODN_TIMER_PRESCALE_EN is defined.
module modn_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick_in,
    output logic tick_out
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_c;

    // Last position of the divide group; always true when PRESCALE is 1.
    assign last_c   = (cnt_q == CW'(PRESCALE - 1));
    assign tick_out = tick_in & last_c;

    // Next count: restart on clear, wrap after the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick_in) begin
            cnt_d = last_c ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/modn_down_timer.sv
// Loadable mod-N down-counter / timer with terminal-count and borrow pulses.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start        - load clamped load_val and begin counting
//   stop         - abort, return to IDLE, hold q
//   tick_en      - count qualifier (one decrement per qualified tick in RUN)
//   auto_reload  - wrap 0 -> reload value instead of finishing (latched at start)
//   load_val     - start/reload value, clamped to N-1
//   q            - current count
//   busy         - high while in RUN
//   done         - one-cycle pulse when q first reads 0
//   borrow       - one-cycle pulse when q reads the reload value after a wrap
// Build option: MODN_TIMER_PRESCALE_EN inserts a divide-by-PRESCALE on tick_en.
module modn_down_timer #(
    parameter int unsigned N        = 12,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_en,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             borrow
);

    import modn_pkg::*;

    // Elaboration-time parameter sanity.
    if (N < 1 || N > (2 ** WIDTH)) begin : g_bad_n
        $error("modn_down_timer: N must be in 1..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("modn_down_timer: PRESCALE must be >= 1");
    end

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH-1:0] load_v_c;
    logic             tick_c;

    assign load_v_c = WIDTH'(clamp_to_mod(32'(load_val), N));

    // Qualified tick source.
`ifdef MODN_TIMER_PRESCALE_EN
    modn_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (start | stop),
        .tick_in  (tick_en),
        .tick_out (tick_c)
    );
`else
    assign tick_c = tick_en;
`endif

    // Next-state and output logic. Priority: stop > start > tick.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = 1'b0;

        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (start) begin
            // Same load from every state. A zero load reaches terminal count
            // at once; in auto-reload mode it keeps running so every later
            // tick wraps 0 -> 0 with a borrow.
            reload_d = load_v_c;
            mode_d   = auto_reload;
            q_d      = load_v_c;
            if (load_v_c == '0) begin
                done_d  = 1'b1;
                state_d = auto_reload ? RUN : DONE;
                busy_d  = auto_reload;
            end else begin
                state_d = RUN;
                busy_d  = 1'b1;
            end
        end else if (state_q == RUN && tick_c) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else if (q_q == WIDTH'(1)) begin
                q_d    = '0;
                done_d = 1'b1;
                if (!mode_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end else begin
                // q == 0 only persists in RUN in auto-reload mode.
                q_d      = reload_q;
                borrow_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_modn_down_timer.sv
// Directed self-checking bench for modn_down_timer (N=12, WIDTH=4, PRESCALE=4).
// Observed word per check is {q, busy, done, borrow}.
module tb_modn_down_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       tick_en;
    logic       auto_reload;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       borrow;

    int checks;
    int errors;

    modn_down_timer #(
        .N        (12),
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .tick_en     (tick_en),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .borrow      (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; tick_en = 1'b1;
        auto_reload = 1'b0; load_val = 4'd0;
        step(); step();
        reset = 1'b0; tick_en = 1'b0;
        checks++;
        if ({q, busy, done, borrow} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_values: got q=%0d busy=%b done=%b borrow=%b, want all 0", q, busy, done, borrow);
        end
        tick_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({q, busy, done, borrow} !== 7'b0000_000) begin
                errors++;
                $display("FAIL idle_tick_ignored[%0d]: got q=%0d busy=%b done=%b borrow=%b, want all 0", i, q, busy, done, borrow);
            end
        end
        tick_en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_q;
        load_val = 4'd5; auto_reload = 1'b0; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({q, busy, done, borrow} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_load: got q=%0d busy=%b done=%b, want q=5 busy=1 done=0", q, busy, done);
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_q = (i <= 5) ? 4'(5 - i) : 4'd0;
            checks++;
            if ({q, busy, done, borrow} !== {exp_q, (i < 5), (i == 5), 1'b0}) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: got q=%0d busy=%b done=%b borrow=%b, want q=%0d busy=%b done=%b borrow=0",
                         i, q, busy, done, borrow, exp_q, (i < 5), (i == 5));
            end
        end
        tick_en = 1'b0;
    endtask

    task automatic test_clamp();
        load_val = 4'd15; auto_reload = 1'b0; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({q, busy, done} !== {4'd11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clamp_load: got q=%0d busy=%b done=%b, want q=11 busy=1 done=0", q, busy, done);
        end
        for (int i = 1; i <= 11; i++) begin
            step();
            checks++;
            if ({q, busy, done} !== {4'(11 - i), (i < 11), (i == 11)}) begin
                errors++;
                $display("FAIL clamp_count[%0d]: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                         i, q, busy, done, 11 - i, (i < 11), (i == 11));
            end
        end
        // Zero load: immediate terminal count, never busy.
        load_val = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({q, busy, done, borrow} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_load: got q=%0d busy=%b done=%b borrow=%b, want q=0 busy=0 done=1 borrow=0", q, busy, done, borrow);
        end
        step();
        checks++;
        if ({q, busy, done, borrow} !== 7'b0000_000) begin
            errors++;
            $display("FAIL zero_load_after: got q=%0d busy=%b done=%b borrow=%b, want all 0", q, busy, done, borrow);
        end
        tick_en = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_q;
        load_val = 4'd11; auto_reload = 1'b1; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0; auto_reload = 1'b0;   // mode already latched
        checks++;
        if ({q, busy, done, borrow} !== {4'd11, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL auto_load: got q=%0d busy=%b done=%b borrow=%b, want q=11 busy=1", q, busy, done, borrow);
        end
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_q = 4'((23 - (i % 12)) % 12);
            checks++;
            if ({q, busy, done, borrow} !== {exp_q, 1'b1, (i % 12 == 11), (i % 12 == 0)}) begin
                errors++;
                $display("FAIL auto_seq[%0d]: got q=%0d busy=%b done=%b borrow=%b, want q=%0d busy=1 done=%b borrow=%b",
                         i, q, busy, done, borrow, exp_q, (i % 12 == 11), (i % 12 == 0));
            end
        end
        stop = 1'b1; tick_en = 1'b0;
        step();
        stop = 1'b0;
    endtask

    task automatic test_stop_restart();
        load_val = 4'd10; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0; tick_en = 1'b1;
        step(); step(); step();
        checks++;
        if ({q, busy} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL pre_stop: got q=%0d busy=%b, want q=7 busy=1", q, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({q, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold: got q=%0d busy=%b done=%b, want q=7 busy=0 done=0", q, busy, done);
        end
        step(); step(); step();
        checks++;
        if ({q, busy, done} !== {4'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_ticks_ignored: got q=%0d busy=%b done=%b, want q=7 busy=0 done=0", q, busy, done);
        end
        // start and stop together from IDLE: stop wins.
        load_val = 4'd5; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({q, busy} !== {4'd7, 1'b0}) begin
            errors++;
            $display("FAIL start_stop_idle: got q=%0d busy=%b, want q=7 busy=0", q, busy);
        end
        // Restart while running at q=4.
        load_val = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if ({q, busy} !== {4'd4, 1'b1}) begin
            errors++;
            $display("FAIL pre_restart: got q=%0d busy=%b, want q=4 busy=1", q, busy);
        end
        load_val = 4'd9; start = 1'b1;
        step();
        start = 1'b0; tick_en = 1'b0;
        checks++;
        if ({q, busy, done} !== {4'd9, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart_run: got q=%0d busy=%b done=%b, want q=9 busy=1 done=0", q, busy, done);
        end
        // start and stop together while running: stop wins, q holds.
        load_val = 4'd3; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({q, busy} !== {4'd9, 1'b0}) begin
            errors++;
            $display("FAIL start_stop_run: got q=%0d busy=%b, want q=9 busy=0", q, busy);
        end
    endtask

    task automatic test_zero_auto();
        load_val = 4'd0; auto_reload = 1'b1; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({q, busy, done, borrow} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_auto_start: got q=%0d busy=%b done=%b borrow=%b, want q=0 busy=1 done=1 borrow=0", q, busy, done, borrow);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({q, busy, done, borrow} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL zero_auto_tick[%0d]: got q=%0d busy=%b done=%b borrow=%b, want q=0 busy=1 done=0 borrow=1", i, q, busy, done, borrow);
            end
        end
        stop = 1'b1; tick_en = 1'b0; auto_reload = 1'b0;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_val = 4'd6; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if ({q, busy} !== {4'd3, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: got q=%0d busy=%b, want q=3 busy=1", q, busy);
        end
        reset = 1'b1; start = 1'b1; load_val = 4'd8;
        step();
        reset = 1'b0; start = 1'b0; tick_en = 1'b0;
        checks++;
        if ({q, busy, done, borrow} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_mid: got q=%0d busy=%b done=%b borrow=%b, want all 0", q, busy, done, borrow);
        end
    endtask

    task automatic test_prescale();
        load_val = 4'd2; auto_reload = 1'b0; start = 1'b1; tick_en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if ({q, busy, done} !== {((i < 4) ? 4'd2 : (i < 8) ? 4'd1 : 4'd0), (i < 8), (i == 8)}) begin
                errors++;
                $display("FAIL prescale[%0d]: got q=%0d busy=%b done=%b", i, q, busy, done);
            end
        end
        tick_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
`ifdef MODN_TIMER_PRESCALE_EN
        test_prescale();
`else
        test_oneshot();
        test_clamp();
        test_auto_reload();
        test_stop_restart();
        test_zero_auto();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
